// File: rtl/idelay_eye_scanner.sv
// idelay_eye_scanner: sweeps IDELAY taps per lane, logs samples to a result RAM and reports the widest eye
// Ports: lb_clk/rst (sync, active-high); start/autoset_en/lane_first/lane_last/pattern scan request;
//   host_addr/host_data/host_write host IDELAY path; adc_val/adc_valid sample input; lane_sel data mux select;
//   hw_addr/hw_data/hw_strobe IDELAY bus; result_addr/result_data/result_write result RAM;
//   opt_strobe/opt_lane/opt_tap/opt_len/opt_good per-lane report; busy/done/host_collision status.
module idelay_eye_scanner #(
  parameter int LW = 4,
  parameter int TW = 5,
  parameter int DW = 8,
  parameter int SW = 2,
  parameter int SETTLE = 32,
  parameter int MIN_EYE = 4,
  parameter int DEFAULT_TAP = 0
) (
  input  logic                lb_clk,
  input  logic                rst,
  input  logic                start,
  input  logic                autoset_en,
  input  logic [LW-1:0]       lane_first,
  input  logic [LW-1:0]       lane_last,
  input  logic [DW-1:0]       pattern,
  input  logic [LW-1:0]       host_addr,
  input  logic [TW-1:0]       host_data,
  input  logic                host_write,
  input  logic [DW-1:0]       adc_val,
  input  logic                adc_valid,
  output logic [LW-1:0]       lane_sel,
  output logic [LW-1:0]       hw_addr,
  output logic [TW-1:0]       hw_data,
  output logic                hw_strobe,
  output logic [LW+TW+SW-1:0] result_addr,
  output logic [DW-1:0]       result_data,
  output logic                result_write,
  output logic                opt_strobe,
  output logic [LW-1:0]       opt_lane,
  output logic [TW-1:0]       opt_tap,
  output logic [TW:0]         opt_len,
  output logic                opt_good,
  output logic                busy,
  output logic                done,
  output logic                host_collision
);
  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_END = CW'(SETTLE - 1);
  localparam logic [TW:0] MIN_LEN = (TW + 1)'(MIN_EYE);
  localparam logic [TW-1:0] DEF_TAP = TW'(DEFAULT_TAP);
  typedef enum logic [3:0] {S_IDLE, S_PUSH, S_SETTLE, S_SAMPLE, S_EVAL, S_REPORT, S_APPLY, S_NEXT, S_DONE} state_t;
  state_t state_q, state_d;
  logic [LW-1:0] lane_q, lane_d, last_q, last_d;
  logic [DW-1:0] pat_q, pat_d;
  logic auto_q, auto_d;
  logic [TW-1:0] tap_q, tap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] idx_q, idx_d;
  logic ok_q, ok_d;
  logic [TW-1:0] run_start_q, run_start_d, best_start_q, best_start_d, cand_start;
  logic [TW:0] run_len_q, run_len_d, best_len_q, best_len_d, cand_len;
  logic [LW-1:0] hw_addr_q, hw_addr_d;
  logic [TW-1:0] hw_data_q, hw_data_d;
  logic hw_strobe_q, hw_strobe_d;
  logic [LW+TW+SW-1:0] res_addr_q, res_addr_d;
  logic [DW-1:0] res_data_q, res_data_d;
  logic res_write_q, res_write_d;
  logic opt_strobe_q, opt_strobe_d, opt_good_q, opt_good_d;
  logic [LW-1:0] opt_lane_q, opt_lane_d;
  logic [TW-1:0] opt_tap_q, opt_tap_d;
  logic [TW:0] opt_len_q, opt_len_d;
  logic done_q, done_d, coll_q, coll_d;
  // Run as it stands after including the tap under evaluation
  assign cand_len = ok_q ? run_len_q + 1'b1 : run_len_q;
  assign cand_start = (ok_q && run_len_q == '0) ? tap_q : run_start_q;
  always_comb begin
    state_d = state_q;
    lane_d = lane_q;
    last_d = last_q;
    pat_d = pat_q;
    auto_d = auto_q;
    tap_d = tap_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    ok_d = ok_q;
    run_start_d = run_start_q;
    run_len_d = run_len_q;
    best_start_d = best_start_q;
    best_len_d = best_len_q;
    hw_addr_d = hw_addr_q;
    hw_data_d = hw_data_q;
    hw_strobe_d = 1'b0;
    res_addr_d = res_addr_q;
    res_data_d = res_data_q;
    res_write_d = 1'b0;
    opt_strobe_d = 1'b0;
    opt_lane_d = opt_lane_q;
    opt_tap_d = opt_tap_q;
    opt_len_d = opt_len_q;
    opt_good_d = opt_good_q;
    done_d = 1'b0;
    coll_d = coll_q || (host_write && state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        hw_addr_d = host_addr;
        hw_data_d = host_data;
        hw_strobe_d = host_write;
        // done_q marks the cycle after DONE; a start there is ignored
        if (start && !done_q) begin
          lane_d = lane_first;
          last_d = lane_last;
          pat_d = pattern;
          auto_d = autoset_en;
          coll_d = 1'b0;
          state_d = lane_first > lane_last ? S_DONE : S_PUSH;
        end
      end
      S_PUSH: begin
        hw_strobe_d = 1'b1;
        hw_addr_d = lane_q;
        hw_data_d = tap_q;
        cnt_d = '0;
        idx_d = '0;
        ok_d = 1'b1;
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == SETTLE_END ? S_SAMPLE : S_SETTLE;
      end
      S_SAMPLE: if (adc_valid) begin
        res_write_d = 1'b1;
        res_addr_d = {lane_q, tap_q, idx_q};
        res_data_d = adc_val;
        ok_d = ok_q && adc_val == pat_q;
        idx_d = idx_q + 1'b1;
        state_d = idx_q == '1 ? S_EVAL : S_SAMPLE;
      end
      S_EVAL: begin
        run_len_d = ok_q ? cand_len : '0;
        run_start_d = cand_start;
        // Strictly greater keeps the earliest of equal runs
        if ((!ok_q || tap_q == '1) && cand_len > best_len_q) begin
          best_len_d = cand_len;
          best_start_d = cand_start;
        end
        tap_d = tap_q + 1'b1;
        state_d = tap_q == '1 ? S_REPORT : S_PUSH;
      end
      S_REPORT: begin
        opt_strobe_d = 1'b1;
        opt_lane_d = lane_q;
        opt_len_d = best_len_q;
        opt_good_d = best_len_q >= MIN_LEN;
        opt_tap_d = best_len_q == '0 ? '0 : best_start_q + TW'((best_len_q - 1'b1) >> 1);
        state_d = auto_q ? S_APPLY : S_NEXT;
      end
      S_APPLY: begin
        hw_strobe_d = 1'b1;
        hw_addr_d = lane_q;
        hw_data_d = opt_good_q ? opt_tap_q : DEF_TAP;
        state_d = S_NEXT;
      end
      S_NEXT: begin
        tap_d = '0;
        run_len_d = '0;
        run_start_d = '0;
        best_len_d = '0;
        best_start_d = '0;
        lane_d = lane_q == last_q ? lane_q : lane_q + 1'b1;
        state_d = lane_q == last_q ? S_DONE : S_PUSH;
      end
      S_DONE: begin
        done_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge lb_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      lane_q <= '0;
      last_q <= '0;
      pat_q <= '0;
      auto_q <= 1'b0;
      tap_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      ok_q <= 1'b0;
      run_start_q <= '0;
      run_len_q <= '0;
      best_start_q <= '0;
      best_len_q <= '0;
      hw_addr_q <= '0;
      hw_data_q <= '0;
      hw_strobe_q <= 1'b0;
      res_addr_q <= '0;
      res_data_q <= '0;
      res_write_q <= 1'b0;
      opt_strobe_q <= 1'b0;
      opt_lane_q <= '0;
      opt_tap_q <= '0;
      opt_len_q <= '0;
      opt_good_q <= 1'b0;
      done_q <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q <= lane_d;
      last_q <= last_d;
      pat_q <= pat_d;
      auto_q <= auto_d;
      tap_q <= tap_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      ok_q <= ok_d;
      run_start_q <= run_start_d;
      run_len_q <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q <= best_len_d;
      hw_addr_q <= hw_addr_d;
      hw_data_q <= hw_data_d;
      hw_strobe_q <= hw_strobe_d;
      res_addr_q <= res_addr_d;
      res_data_q <= res_data_d;
      res_write_q <= res_write_d;
      opt_strobe_q <= opt_strobe_d;
      opt_lane_q <= opt_lane_d;
      opt_tap_q <= opt_tap_d;
      opt_len_q <= opt_len_d;
      opt_good_q <= opt_good_d;
      done_q <= done_d;
      coll_q <= coll_d;
    end
  end
  assign lane_sel = lane_q;
  assign hw_addr = hw_addr_q;
  assign hw_data = hw_data_q;
  assign hw_strobe = hw_strobe_q;
  assign result_addr = res_addr_q;
  assign result_data = res_data_q;
  assign result_write = res_write_q;
  assign opt_strobe = opt_strobe_q;
  assign opt_lane = opt_lane_q;
  assign opt_tap = opt_tap_q;
  assign opt_len = opt_len_q;
  assign opt_good = opt_good_q;
  assign busy = state_q != S_IDLE;
  assign done = done_q;
  assign host_collision = coll_q;
endmodule

// File: tb/tb_idelay_eye_scanner.sv
// tb_idelay_eye_scanner: directed self-checking bench for idelay_eye_scanner
module tb_idelay_eye_scanner;
  logic lb_clk, rst, start, autoset_en, host_write, adc_valid;
  logic [3:0] lane_first, lane_last, host_addr;
  logic [7:0] pattern, adc_val;
  logic [4:0] host_data;
  logic [3:0] lane_sel, hw_addr, opt_lane;
  logic [4:0] hw_data, opt_tap;
  logic hw_strobe, result_write, opt_strobe, opt_good, busy, done, host_collision;
  logic [10:0] result_addr;
  logic [7:0] result_data;
  logic [5:0] opt_len;
  logic [31:0] good_mask;
  logic [7:0] pat;
  logic [4:0] cur_tap;
  logic track;
  int n_cmp, n_bad;
  int hw_cnt, wr_cnt, done_cnt, opt_cnt, host9_cnt, trk_opt, opt_bad;
  int last_hw_addr, last_hw_data, last_opt_tap, last_opt_len, last_opt_good, last_opt_lane;
  int addr_cnt [2048];
  int h0, w0, d0, o0, miss;

  idelay_eye_scanner #(.DEFAULT_TAP(7)) dut (
    .lb_clk(lb_clk), .rst(rst), .start(start), .autoset_en(autoset_en),
    .lane_first(lane_first), .lane_last(lane_last), .pattern(pattern),
    .host_addr(host_addr), .host_data(host_data), .host_write(host_write),
    .adc_val(adc_val), .adc_valid(adc_valid), .lane_sel(lane_sel),
    .hw_addr(hw_addr), .hw_data(hw_data), .hw_strobe(hw_strobe),
    .result_addr(result_addr), .result_data(result_data), .result_write(result_write),
    .opt_strobe(opt_strobe), .opt_lane(opt_lane), .opt_tap(opt_tap), .opt_len(opt_len),
    .opt_good(opt_good), .busy(busy), .done(done), .host_collision(host_collision)
  );

  initial lb_clk = 1'b0;
  always #5 lb_clk = ~lb_clk;

  assign adc_val = good_mask[cur_tap] ? pat : ~pat;

  initial begin
    cur_tap = '0;
    hw_cnt = 0; wr_cnt = 0; done_cnt = 0; opt_cnt = 0; host9_cnt = 0; trk_opt = 0; opt_bad = 0;
    last_hw_addr = 0; last_hw_data = 0; last_opt_tap = 0; last_opt_len = 0; last_opt_good = 0; last_opt_lane = 0;
  end

  always @(negedge lb_clk) begin
    if (hw_strobe) begin
      cur_tap = hw_data;
      hw_cnt++;
      last_hw_addr = int'(hw_addr);
      last_hw_data = int'(hw_data);
      if (hw_addr == 4'd9) host9_cnt++;
    end
    if (result_write) begin
      wr_cnt++;
      if (track) addr_cnt[result_addr]++;
    end
    if (opt_strobe) begin
      opt_cnt++;
      last_opt_tap = int'(opt_tap);
      last_opt_len = int'(opt_len);
      last_opt_good = int'(opt_good);
      last_opt_lane = int'(opt_lane);
      if (track) begin
        if (opt_len !== 6'd32 || opt_tap !== 5'd15 || opt_lane !== 4'(trk_opt)) opt_bad++;
        trk_opt++;
      end
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic scan(input logic [3:0] f, input logic [3:0] l, input logic au, input logic [7:0] p);
    @(negedge lb_clk);
    lane_first = f; lane_last = l; autoset_en = au; pattern = p; pat = p; start = 1'b1;
    @(negedge lb_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int k;
    k = 0;
    while (!done && k < lim) begin
      @(negedge lb_clk);
      k++;
    end
    chk("done_timeout", int'(k < lim), 1);
    @(negedge lb_clk);
    @(negedge lb_clk);
  endtask

  task automatic mark();
    h0 = hw_cnt; w0 = wr_cnt; d0 = done_cnt; o0 = opt_cnt;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; track = 1'b0;
    rst = 1'b1; start = 1'b0; autoset_en = 1'b0; lane_first = '0; lane_last = '0; pattern = '0;
    host_addr = '0; host_data = '0; host_write = 1'b0; adc_valid = 1'b1; good_mask = '0; pat = 8'hA5;
    repeat (3) @(negedge lb_clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_hw_strobe", int'(hw_strobe), 0);
    chk("rst_result_write", int'(result_write), 0);
    chk("rst_opt_strobe", int'(opt_strobe), 0);
    chk("rst_collision", int'(host_collision), 0);
    chk("rst_lane_sel", int'(lane_sel), 0);
    rst = 1'b0;
    @(negedge lb_clk);
    host_addr = 4'd5; host_data = 5'd9; host_write = 1'b1;
    @(negedge lb_clk);
    host_write = 1'b0;
    chk("idle_hw_strobe", int'(hw_strobe), 1);
    chk("idle_hw_addr", int'(hw_addr), 5);
    chk("idle_hw_data", int'(hw_data), 9);
    @(negedge lb_clk);
    chk("idle_hw_strobe_off", int'(hw_strobe), 0);

    good_mask = 32'h0003FC00; mark();
    scan(4'd3, 4'd3, 1'b1, 8'hA5);
    chk("t1_busy", int'(busy), 1);
    chk("t1_lane_sel", int'(lane_sel), 3);
    repeat (5) @(negedge lb_clk);
    host_addr = 4'd9; host_data = 5'd1; host_write = 1'b1;
    @(negedge lb_clk);
    host_write = 1'b0;
    chk("t1_collision", int'(host_collision), 1);
    wait_done(30000);
    chk("t1_opt_tap", last_opt_tap, 13);
    chk("t1_opt_len", last_opt_len, 8);
    chk("t1_opt_good", last_opt_good, 1);
    chk("t1_opt_lane", last_opt_lane, 3);
    chk("t1_apply_addr", last_hw_addr, 3);
    chk("t1_apply_data", last_hw_data, 13);
    chk("t1_hw_strobes", hw_cnt - h0, 33);
    chk("t1_writes", wr_cnt - w0, 128);
    chk("t1_done_pulses", done_cnt - d0, 1);
    chk("t1_host_strobes", host9_cnt, 0);
    chk("t1_collision_sticky", int'(host_collision), 1);

    good_mask = 32'h00F0003C; mark();
    scan(4'd0, 4'd0, 1'b0, 8'hA5);
    chk("t2_collision_clr", int'(host_collision), 0);
    wait_done(30000);
    chk("t2_opt_tap", last_opt_tap, 3);
    chk("t2_opt_len", last_opt_len, 4);
    chk("t2_hw_strobes", hw_cnt - h0, 32);

    good_mask = 32'h03F0001C; mark();
    scan(4'd15, 4'd15, 1'b0, 8'h3C);
    wait_done(30000);
    chk("t3_opt_tap", last_opt_tap, 22);
    chk("t3_opt_len", last_opt_len, 6);
    chk("t3_opt_lane", last_opt_lane, 15);
    chk("t3_opt_count", opt_cnt - o0, 1);
    chk("t3_done_pulses", done_cnt - d0, 1);

    good_mask = 32'h0; mark();
    scan(4'd7, 4'd7, 1'b1, 8'hA5);
    wait_done(30000);
    chk("t5_opt_len", last_opt_len, 0);
    chk("t5_opt_good", last_opt_good, 0);
    chk("t5_opt_tap", last_opt_tap, 0);
    chk("t5_apply_addr", last_hw_addr, 7);
    chk("t5_apply_data", last_hw_data, 7);

    good_mask = 32'h000000E0; mark();
    scan(4'd2, 4'd2, 1'b1, 8'hA5);
    wait_done(30000);
    chk("t6_opt_len", last_opt_len, 3);
    chk("t6_opt_good", last_opt_good, 0);
    chk("t6_opt_tap", last_opt_tap, 6);
    chk("t6_apply_data", last_hw_data, 7);

    good_mask = 32'hFFFFFFFF; mark(); track = 1'b1;
    scan(4'd0, 4'd15, 1'b0, 8'hA5);
    wait_done(30000);
    track = 1'b0;
    miss = 0;
    for (int i = 0; i < 2048; i++) if (addr_cnt[i] != 1) miss++;
    chk("t4_opt_count", opt_cnt - o0, 16);
    chk("t4_opt_bad", opt_bad, 0);
    chk("t4_writes", wr_cnt - w0, 2048);
    chk("t4_addr_not_once", miss, 0);
    chk("t4_hw_strobes", hw_cnt - h0, 512);
    chk("t4_done_pulses", done_cnt - d0, 1);

    mark();
    @(negedge lb_clk);
    lane_first = 4'd6; lane_last = 4'd2; start = 1'b1;
    @(negedge lb_clk);
    start = 1'b0;
    chk("t7_busy", int'(busy), 1);
    chk("t7_done_early", int'(done), 0);
    @(negedge lb_clk);
    chk("t7_done", int'(done), 1);
    chk("t7_busy_at_done", int'(busy), 0);
    start = 1'b1;
    @(negedge lb_clk);
    start = 1'b0;
    chk("t7_start_on_done_ignored", int'(busy), 0);
    chk("t7_done_single", int'(done), 0);
    @(negedge lb_clk);
    chk("t7_writes", wr_cnt - w0, 0);
    chk("t7_hw_strobes", hw_cnt - h0, 0);
    chk("t7_done_pulses", done_cnt - d0, 1);

    good_mask = 32'hFFFFFFFF; adc_valid = 1'b0; mark();
    scan(4'd1, 4'd1, 1'b0, 8'hA5);
    repeat (100) @(negedge lb_clk);
    chk("t8_stall_writes", wr_cnt - w0, 0);
    chk("t8_stall_busy", int'(busy), 1);
    adc_valid = 1'b1;
    wait_done(30000);
    chk("t8_writes", wr_cnt - w0, 128);
    chk("t8_opt_len", last_opt_len, 32);

    mark();
    scan(4'd0, 4'd0, 1'b0, 8'hA5);
    for (int k = 0; k < 200 && wr_cnt == w0; k++) @(negedge lb_clk);
    chk("t9_reached_sample", int'(wr_cnt > w0), 1);
    rst = 1'b1;
    @(negedge lb_clk);
    rst = 1'b0;
    chk("t9_busy", int'(busy), 0);
    chk("t9_result_write", int'(result_write), 0);
    chk("t9_hw_strobe", int'(hw_strobe), 0);
    w0 = wr_cnt;
    repeat (60) @(negedge lb_clk);
    chk("t9_no_done", done_cnt - d0, 0);
    chk("t9_no_writes", wr_cnt - w0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/idelay_eye_scanner.md
Name: idelay_eye_scanner

Overview:
- Parametrised successor to the 16-lane IDELAY scan engine.
- For a host-selected range of lanes, it sweeps every IDELAY tap and captures 2^SW samples per tap into an external result RAM.
- Each sample is checked against an expected training pattern, and the longest contiguous run of good taps (the "eye") is tracked per lane.
- Optionally drives the eye-centre tap to hardware. Sits between the host local bus and the IDELAYE2 control bus; single lb_clk domain, ADC data already synchronised upstream.

Parameters:
LW, 4, lane address width; lanes 0..2^LW-1
TW, 5, tap width; taps 0..2^TW-1
DW, 8, sample/pattern width
SW, 2, log2 samples captured per tap
SETTLE, 32, lb_clk cycles waited after each tap write before sampling (>=1)
MIN_EYE, 4, minimum eye length (taps) for a lane to count as good
DEFAULT_TAP, 0, tap written back for a failed lane in autoset mode

Ports:
lb_clk  in  1  sole clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle scan request; ignored while busy
autoset_en  in  1  sampled at accepted start
lane_first  in  LW  first lane scanned, sampled at start
lane_last  in  LW  last lane scanned, inclusive, sampled at start
pattern  in  DW  expected sample value, sampled at start
host_addr  in  LW  host IDELAY lane address
host_data  in  TW  host IDELAY tap value
host_write  in  1  host IDELAY write strobe
adc_val  in  DW  selected lane data, lb_clk domain
adc_valid  in  1  adc_val qualifier
lane_sel  out  LW  lane currently scanned, for external data mux
hw_addr  out  LW  IDELAY lane address
hw_data  out  TW  IDELAY tap value
hw_strobe  out  1  IDELAY load strobe
result_addr  out  LW+TW+SW  {lane, tap, sample index}
result_data  out  DW  captured sample
result_write  out  1  result RAM write enable
opt_strobe  out  1  one cycle per finished lane
opt_lane  out  LW  lane of this report
opt_tap  out  TW  chosen eye centre
opt_len  out  TW+1  best eye length, 0..2^TW
opt_good  out  1  opt_len >= MIN_EYE
busy  out  1  scan in progress
done  out  1  one-cycle pulse at scan end
host_collision  out  1  sticky: host_write seen while busy; cleared by accepted start or rst

Behaviour:
- Reset: all outputs 0; state IDLE; eye trackers cleared.
- Mid-scan rst aborts on the next edge: hw_strobe and result_write are 0 from the following cycle; no done pulse.

Host path:
- In IDLE, hw_addr/hw_data/hw_strobe are host_addr/host_data/host_write registered, 1-cycle latency.
- While busy, host_write is dropped and sets host_collision.

FSM:
- IDLE -> PUSH on start. Latch lane_first, lane_last, pattern and autoset_en; busy=1 from the next cycle.
- If lane_first > lane_last, go directly to DONE; no hw or result writes.
- PUSH: one cycle, hw_strobe=1, hw_addr=lane, hw_data=tap. Then SETTLE.
- SETTLE: count exactly SETTLE cycles, then SAMPLE.
- SAMPLE:
  - Each adc_valid cycle writes adc_val, registered, to result_addr={lane,tap,idx} with result_write=1 one cycle later; idx increments.
  - Tap is good iff all 2^SW samples equal pattern.
  - After sample 2^SW-1 -> EVAL.
  - adc_valid low stalls indefinitely; no timeout.
- EVAL, one cycle, updates run tracking:
  - Good tap: if run_len==0, run_start=tap; run_len++.
  - Bad tap: if run_len>best_len, copy run to best; then run_len=0.
  - Not last tap: tap++ -> PUSH.
  - Last tap: final run-vs-best compare -> REPORT.
  - Strict greater: on a tie the earliest run wins.
  - All taps good gives best_len=2^TW and best_start=0.
- REPORT, one cycle:
  - opt_strobe=1.
  - opt_tap = best_start + ((best_len-1)>>1), floor centre, TW-bit truncation impossible by construction.
  - If best_len==0: opt_tap=0, opt_len=0, opt_good=0.
  - Next state: APPLY if autoset, else NEXT.
- APPLY: one-cycle hw_strobe with hw_data = opt_good ? opt_tap : DEFAULT_TAP.
- NEXT: clear trackers and tap.
  - lane==lane_last -> DONE.
  - Otherwise lane++ -> PUSH.
  - lane_last = 2^LW-1 terminates without lane wrap.
- DONE: done=1 for one cycle, busy=0 -> IDLE. A start coincident with done is ignored.
- lane_sel equals the current scan lane throughout the scan; it holds its last value when idle.

Test Plan:
- Single lane 3, autoset on, SETTLE=32, pattern 0xA5; data == 0xA5 only at taps 10..17 -> opt_tap=13, opt_len=8, opt_good=1; APPLY writes hw_data=13 to hw_addr=3; done pulses once.
- Two eyes, taps 2..5 and 20..23, equal length -> opt_tap=3 (earliest wins). Eyes 2..4 and 20..25 -> opt_tap=22, opt_len=6.
- All taps good, lanes 0..15, autoset off -> 16 opt_strobe, each opt_len=32, opt_tap=15. Zero hw_strobe outside PUSH. Result writes: 16*32*4=2048, addresses 0..2047 each exactly once.
- No good taps, autoset on, DEFAULT_TAP=7 -> opt_len=0, opt_good=0, APPLY writes 7. Eye of 3 taps with MIN_EYE=4 -> opt_good=0, also writes 7.
- host_write during scan -> no hw_strobe from host, host_collision=1, cleared on next start. Idle host write (addr 5, data 9) -> hw_* appear 1 cycle later.
- rst asserted in SAMPLE -> next cycle busy=0, result_write=0, no done. lane_first=6 > lane_last=2 -> done two cycles after start with no writes. adc_valid held low 100 cycles -> FSM stalls in SAMPLE with no writes, then resumes.
